jtbubl_romarb: RTL



---
 rtl/jtbubl_romarb_pkg.sv | 26 ++
 rtl/jtbubl_romarb_slot.sv | 43 ++++
 rtl/jtbubl_romarb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/jtbubl_romarb_pkg.sv
// Shared definitions for the three-port ROM arbiter: FSM encoding,
// requester count and the round-robin pick helper.
package jtbubl_romarb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DATA = 2'd2
   } state_t;

   localparam int NREQ = 3;

   // Walk from the highest-numbered candidate down so that the port right after
   // 'last' is written last and therefore wins.
   function automatic logic [1:0] rrPick(input logic [NREQ-1:0] pend, input logic [1:0] last);
      logic [1:0] pick;
      int         idx;
      pick = 2'd0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NREQ;
         if (pend[idx]) pick = 2'(idx);
      end
      return pick;
   endfunction

endpackage

// File: rtl/jtbubl_romarb_slot.sv
// One requester's single-word cache entry: holds valid/tag/word, answers hits
// combinationally and steers the addressed byte onto the port.
module jtbubl_romarb_slot #(
   parameter int AW = 17
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_downloading,
   input  logic          i_cs,
   input  logic [AW-1:0] i_addr,
   input  logic          i_fill,
   input  logic [AW-2:0] i_ftag,
   input  logic [15:0]   i_word,
   output logic          o_ok,
   output logic [7:0]    o_data
);

   logic          r_valid;
   logic [AW-2:0] r_tag;
   logic [15:0]   r_word;
   logic          w_tagMatch;

   // A fill that lands while a download is running is dropped, so the entry
   // can never hold data from before the new ROM image.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_word  <= '0;
      end else if (i_downloading) begin
         r_valid <= 1'b0;
      end else if (i_fill) begin
         r_valid <= 1'b1;
         r_tag   <= i_ftag;
         r_word  <= i_word;
      end
   end

   assign w_tagMatch = (r_tag == i_addr[AW-1:1]);
   assign o_ok       = i_cs & r_valid & w_tagMatch & ~i_downloading;
   assign o_data     = i_addr[0] ? r_word[15:8] : r_word[7:0];

endmodule

// File: rtl/jtbubl_romarb.sv
// Three-port ROM bandwidth arbiter: per-port one-word caches in front of a
// single 16-bit SDRAM read channel, misses served round-robin.
module jtbubl_romarb
   import jtbubl_romarb_pkg::*;
#(
   parameter int          AW    = 17,
   parameter logic [21:0] BASE0 = 22'h00000,
   parameter logic [21:0] BASE1 = 22'h10000,
   parameter logic [21:0] BASE2 = 22'h14000
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          downloading,
   input  logic          r0_cs,
   input  logic [AW-1:0] r0_addr,
   output logic [7:0]    r0_data,
   output logic          r0_ok,
   input  logic          r1_cs,
   input  logic [AW-1:0] r1_addr,
   output logic [7:0]    r1_data,
   output logic          r1_ok,
   input  logic          r2_cs,
   input  logic [AW-1:0] r2_addr,
   output logic [7:0]    r2_data,
   output logic          r2_ok,
   output logic          sdram_req,
   output logic [21:0]   sdram_addr,
   input  logic          sdram_ack,
   input  logic          data_rdy,
   input  logic [15:0]   data_read
);

   state_t          r_state;
   state_t          w_stateNext;
   logic [1:0]      r_gnt;
   logic [1:0]      r_last;
   logic [AW-2:0]   r_ftag;
   logic [21:0]     r_sdramAddr;

   logic [NREQ-1:0] w_cs;
   logic [AW-1:0]   w_addr [NREQ];
   logic [NREQ-1:0] w_ok;
   logic [7:0]      w_data [NREQ];
   logic [NREQ-1:0] w_pend;
   logic [NREQ-1:0] w_fill;
   logic            w_fillEn;
   logic            w_sdramReq;
   logic [1:0]      w_gntNext;
   logic [AW-2:0]   w_gntTag;
   logic [21:0]     w_gntBase;

   assign w_cs      = {r2_cs, r1_cs, r0_cs};
   assign w_addr[0] = r0_addr;
   assign w_addr[1] = r1_addr;
   assign w_addr[2] = r2_addr;
   assign w_pend    = w_cs & ~w_ok & {NREQ{~downloading}};

   for (genvar g = 0; g < NREQ; g++) begin : g_slot
      jtbubl_romarb_slot #(.AW(AW)) u_slot (
         .clk           (clk),
         .rst           (rst),
         .i_downloading (downloading),
         .i_cs          (w_cs[g]),
         .i_addr        (w_addr[g]),
         .i_fill        (w_fill[g]),
         .i_ftag        (r_ftag),
         .i_word        (data_read),
         .o_ok          (w_ok[g]),
         .o_data        (w_data[g])
      );
   end

   // Candidate grant for the next IDLE cycle, plus its tag and SDRAM base.
   always_comb begin
      w_gntNext = rrPick(w_pend, r_last);
      w_gntTag  = r2_addr[AW-1:1];
      w_gntBase = BASE2;
      case (w_gntNext)
         2'd0: begin
            w_gntTag  = r0_addr[AW-1:1];
            w_gntBase = BASE0;
         end
         2'd1: begin
            w_gntTag  = r1_addr[AW-1:1];
            w_gntBase = BASE1;
         end
         default: begin
            w_gntTag  = r2_addr[AW-1:1];
            w_gntBase = BASE2;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_stateNext;
   end

   // Next-state logic; an ack arriving together with its data skips WAIT_DATA.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:      if (|w_pend)   w_stateNext = WAIT_ACK;
         WAIT_ACK:  if (sdram_ack) w_stateNext = data_rdy ? IDLE : WAIT_DATA;
         WAIT_DATA: if (data_rdy)  w_stateNext = IDLE;
         default:                  w_stateNext = IDLE;
      endcase
   end

   // FSM outputs: request level and the per-slot fill strobe.
   always_comb begin
      w_fillEn   = 1'b0;
      w_sdramReq = 1'b0;
      case (r_state)
         WAIT_ACK: begin
            w_sdramReq = 1'b1;
            w_fillEn   = sdram_ack & data_rdy;
         end
         WAIT_DATA: w_fillEn = data_rdy;
         default:   w_fillEn = 1'b0;
      endcase
      for (int i = 0; i < NREQ; i++) w_fill[i] = w_fillEn & (r_gnt == 2'(i));
   end

   // Grant bookkeeping: the tag is frozen at grant time so the transfer can
   // finish even if the requester moves on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt       <= 2'd0;
         r_last      <= 2'd2;
         r_ftag      <= '0;
         r_sdramAddr <= '0;
      end else begin
         if (r_state == IDLE && |w_pend) begin
            r_gnt       <= w_gntNext;
            r_ftag      <= w_gntTag;
            r_sdramAddr <= w_gntBase + 22'(w_gntTag);
         end
         if (w_fillEn) r_last <= r_gnt;
      end
   end

   assign sdram_req  = w_sdramReq;
   assign sdram_addr = r_sdramAddr;
   assign r0_ok      = w_ok[0];
   assign r1_ok      = w_ok[1];
   assign r2_ok      = w_ok[2];
   assign r0_data    = w_data[0];
   assign r1_data    = w_data[1];
   assign r2_data    = w_data[2];

endmodule
